// File: rtl/hbridge_sequencer.sv
// hbridge_sequencer: start-up, run and protection sequencer for the full-bridge
// gate drive. It charges the bootstraps, forces the pre-charge pattern, hands the
// bridge to the controller, and latches OV and shoot-through faults. After a fault
// it holds the gates off and retries a bounded number of times before locking out.
module hbridge_sequencer #(
  parameter int T_BOOT    = 10,
  parameter int T_FORCE   = 4,
  parameter int T_HOLD    = 1000,
  parameter int VOV_LIMIT = 50,
  parameter int MAX_RETRY = 3,
  parameter int CNT_W     = 16
) (
  input  logic       i_clock,
  input  logic       i_RST,
  input  logic       i_enable,
  input  logic [7:0] i_Vbat,
  input  logic [3:0] i_Q_hc,
  output logic [3:0] o_Q,
  output logic       o_ctrl_rst_n,
  output logic [2:0] o_state,
  output logic [1:0] o_fault,
  output logic [2:0] o_retry
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_BOOT    = 3'd1,
    S_FORCE   = 3'd2,
    S_RUN     = 3'd3,
    S_FAULT   = 3'd4,
    S_LOCKOUT = 3'd5
  } state_t;

  localparam logic [7:0]       VOV        = 8'(VOV_LIMIT);
  localparam logic [2:0]       RETRY_MAX  = 3'(MAX_RETRY);
  localparam logic [CNT_W-1:0] BOOT_LAST  = CNT_W'(T_BOOT - 1);
  localparam logic [CNT_W-1:0] FORCE_LAST = CNT_W'(T_FORCE - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] TMR_SAT    = '1;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [3:0]       q_q, q_d;
  logic             rstn_q, rstn_d;
  logic [1:0]       fault_q, fault_d;
  logic [2:0]       retry_q, retry_d;

  logic ov, shoot, run_st;

  assign ov     = i_Vbat > VOV;
  assign shoot  = (i_Q_hc[0] & i_Q_hc[2]) | (i_Q_hc[1] & i_Q_hc[3]);
  assign run_st = (state_q == S_RUN) && shoot;

  // Next state, fault/retry bookkeeping, timer and registered pin values.
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    retry_d = retry_q;
    if (!i_enable) begin
      state_d = S_IDLE;
      fault_d = 2'b00;
      retry_d = 3'd0;
    end else begin
      case (state_q)
        S_IDLE: if (!ov) state_d = S_BOOT;
        S_BOOT, S_FORCE, S_RUN: begin
          if (ov || run_st) begin
            state_d = S_FAULT;
            fault_d = fault_q | {run_st, ov};
          end else if (state_q == S_BOOT && timer_q == BOOT_LAST) begin
            state_d = S_FORCE;
          end else if (state_q == S_FORCE && timer_q == FORCE_LAST) begin
            state_d = S_RUN;
          end
        end
        S_FAULT: begin
          if (timer_q == HOLD_LAST) begin
            if (retry_q < RETRY_MAX) begin
              retry_d = retry_q + 3'd1;
              state_d = S_BOOT;
            end else begin
              state_d = S_LOCKOUT;
            end
          end
        end
        S_LOCKOUT: state_d = S_LOCKOUT;
        default: begin
          state_d = S_IDLE;
          fault_d = 2'b00;
          retry_d = 3'd0;
        end
      endcase
    end

    // Timer restarts on every state change and saturates instead of wrapping.
    if (state_d != state_q)      timer_d = '0;
    else if (timer_q == TMR_SAT) timer_d = timer_q;
    else                         timer_d = timer_q + 1'b1;

    // Gate pattern follows the state being entered; an overlapping leg
    // pattern is never allowed through, even on the FORCE->RUN edge.
    case (state_d)
      S_BOOT:  q_d = 4'b1100;
      S_FORCE: q_d = 4'b1001;
      S_RUN:   q_d = shoot ? 4'b0000 : i_Q_hc;
      default: q_d = 4'b0000;
    endcase
    rstn_d = (state_d == S_RUN);
  end

  // State and output registers; reset clears the gates asynchronously.
  always_ff @(posedge i_clock or posedge i_RST) begin
    if (i_RST) begin
      state_q <= S_IDLE;
      timer_q <= '0;
      q_q     <= 4'b0000;
      rstn_q  <= 1'b0;
      fault_q <= 2'b00;
      retry_q <= 3'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      q_q     <= q_d;
      rstn_q  <= rstn_d;
      fault_q <= fault_d;
      retry_q <= retry_d;
    end
  end

  assign o_Q          = q_q;
  assign o_ctrl_rst_n = rstn_q;
  assign o_state      = state_q;
  assign o_fault      = fault_q;
  assign o_retry      = retry_q;

endmodule

// File: tb/tb_hbridge_sequencer.sv
// Bench for hbridge_sequencer: directed start-up/fault/retry/reset scenarios with
// literal expectations, then randomized stimulus against a countdown-based model.
module tb_hbridge_sequencer;

  localparam int T_BOOT  = 10;
  localparam int T_FORCE = 4;
  localparam int T_HOLD  = 1000;
  localparam int VOVL    = 50;
  localparam int MAXR    = 3;

  logic       clk, rst, en;
  logic [7:0] vbat;
  logic [3:0] qhc;
  logic [3:0] o_Q;
  logic       o_rstn;
  logic [2:0] o_state;
  logic [1:0] o_fault;
  logic [2:0] o_retry;

  int vectors = 0;
  int errs    = 0;

  hbridge_sequencer #(
    .T_BOOT(T_BOOT), .T_FORCE(T_FORCE), .T_HOLD(T_HOLD),
    .VOV_LIMIT(VOVL), .MAX_RETRY(MAXR), .CNT_W(16)
  ) dut (
    .i_clock(clk), .i_RST(rst), .i_enable(en), .i_Vbat(vbat), .i_Q_hc(qhc),
    .o_Q(o_Q), .o_ctrl_rst_n(o_rstn), .o_state(o_state),
    .o_fault(o_fault), .o_retry(o_retry)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cmp(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: phase number plus cycles remaining in the timed phase.
  int         m_st, m_left, m_r;
  logic [3:0] m_q;
  logic       m_rstn;
  logic [1:0] m_f;
  logic       m_ov, m_ill, m_sh;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_st = 0; m_left = 0; m_r = 0; m_q = 4'b0; m_rstn = 1'b0; m_f = 2'b0;
    end else begin
      m_ov  = int'(vbat) > VOVL;
      m_ill = (qhc[0] & qhc[2]) | (qhc[1] & qhc[3]);
      if (!en) begin
        m_st = 0; m_f = 2'b0; m_r = 0;
      end else begin
        case (m_st)
          0: if (!m_ov) begin m_st = 1; m_left = T_BOOT; end
          1, 2, 3: begin
            m_sh = (m_st == 3) && m_ill;
            if (m_ov || m_sh) begin
              m_f = m_f | {m_sh, m_ov};
              m_st = 4; m_left = T_HOLD;
            end else if (m_st != 3) begin
              m_left--;
              if (m_left == 0) begin
                if (m_st == 1) begin m_st = 2; m_left = T_FORCE; end
                else m_st = 3;
              end
            end
          end
          4: begin
            m_left--;
            if (m_left == 0) begin
              if (m_r < MAXR) begin m_r++; m_st = 1; m_left = T_BOOT; end
              else m_st = 5;
            end
          end
          default: ;
        endcase
      end
      m_q    = (m_st == 1) ? 4'b1100 : (m_st == 2) ? 4'b1001 :
               (m_st == 3 && !m_ill) ? qhc : 4'b0000;
      m_rstn = (m_st == 3);
    end
  end

  // Every cycle out of reset, all outputs must match the model.
  always @(negedge clk) begin
    if (!rst) begin
      cmp("state", int'(o_state), m_st);
      cmp("o_Q",   int'(o_Q),     int'(m_q));
      cmp("rstn",  int'(o_rstn),  int'(m_rstn));
      cmp("fault", int'(o_fault), int'(m_f));
      cmp("retry", int'(o_retry), m_r);
    end
  end

  task automatic lit(input string nm, input int dv, input int mv, input int exp);
    cmp(nm, dv, exp);
    cmp({nm, "_model"}, mv, exp);
  endtask

  task automatic step(input logic e, input logic [7:0] v, input logic [3:0] q,
                      input int n = 1);
    repeat (n) begin
      en = e; vbat = v; qhc = q;
      @(negedge clk);
    end
  endtask

  initial begin
    logic [3:0] rq;
    logic [7:0] rv;
    logic       re;
    int         r;
    rst = 1'b1; en = 1'b0; vbat = 8'd0; qhc = 4'b0;
    #12;
    cmp("rst_state", int'(o_state), 0);
    cmp("rst_Q",     int'(o_Q), 0);
    cmp("rst_rstn",  int'(o_rstn), 0);
    cmp("rst_fault", int'(o_fault), 0);
    cmp("rst_retry", int'(o_retry), 0);
    @(negedge clk);
    rst = 1'b0;

    // Start-up: BOOT 10 cycles, FORCE 4, then RUN.
    step(1, 8'd20, 4'b0110);
    lit("boot_state", int'(o_state), m_st, 1);
    lit("boot_Q", int'(o_Q), int'(m_q), 4'b1100);
    step(1, 8'd20, 4'b0110, 9);
    lit("boot_end", int'(o_state), m_st, 1);
    step(1, 8'd20, 4'b0110);
    lit("force_state", int'(o_state), m_st, 2);
    lit("force_Q", int'(o_Q), int'(m_q), 4'b1001);
    step(1, 8'd20, 4'b0110, 3);
    lit("force_end", int'(o_state), m_st, 2);
    step(1, 8'd20, 4'b0110);
    lit("run_state", int'(o_state), m_st, 3);
    lit("run_rstn", int'(o_rstn), int'(m_rstn), 1);
    lit("run_Q", int'(o_Q), int'(m_q), 4'b0110);
    step(1, 8'd20, 4'b0011);
    lit("run_Q2", int'(o_Q), int'(m_q), 4'b0011);

    // Shoot-through pattern: gates stay off, fault 10, hold then retry.
    step(1, 8'd20, 4'b0101);
    lit("st_state", int'(o_state), m_st, 4);
    lit("st_Q", int'(o_Q), int'(m_q), 0);
    lit("st_fault", int'(o_fault), int'(m_f), 2);
    lit("st_rstn", int'(o_rstn), int'(m_rstn), 0);
    step(1, 8'd20, 4'b0110, T_HOLD - 1);
    lit("hold_end", int'(o_state), m_st, 4);
    step(1, 8'd20, 4'b0110);
    lit("retry_state", int'(o_state), m_st, 1);
    lit("retry_cnt", int'(o_retry), m_r, 1);
    lit("retry_fault", int'(o_fault), int'(m_f), 2);

    // Enable dropped in FORCE.
    step(1, 8'd20, 4'b0110, T_BOOT);
    lit("force2", int'(o_state), m_st, 2);
    step(0, 8'd20, 4'b0110);
    lit("dis_state", int'(o_state), m_st, 0);
    lit("dis_Q", int'(o_Q), int'(m_q), 0);
    lit("dis_fault", int'(o_fault), int'(m_f), 0);
    lit("dis_retry", int'(o_retry), m_r, 0);

    // OV threshold: 50 is fine, 51 trips.
    step(1, 8'd20, 4'b0110, T_BOOT + T_FORCE + 1);
    step(1, 8'd50, 4'b0110);
    lit("vb50_state", int'(o_state), m_st, 3);
    lit("vb50_fault", int'(o_fault), int'(m_f), 0);
    step(1, 8'd51, 4'b0110);
    lit("vb51_state", int'(o_state), m_st, 4);
    lit("vb51_fault", int'(o_fault), int'(m_f), 1);
    lit("vb51_Q", int'(o_Q), int'(m_q), 0);
    step(1, 8'd20, 4'b0110, 5);
    step(0, 8'd20, 4'b0110);
    lit("dis_fault2", int'(o_state), m_st, 0);

    // Persistent OV: three retries then LOCKOUT.
    step(1, 8'd20, 4'b0110, T_BOOT + T_FORCE + 1);
    step(1, 8'd80, 4'b0110, 4 * T_HOLD + 4);
    lit("lock_state", int'(o_state), m_st, 5);
    lit("lock_retry", int'(o_retry), m_r, 3);
    lit("lock_fault", int'(o_fault), int'(m_f), 1);
    step(0, 8'd80, 4'b0110);
    lit("unlock_state", int'(o_state), m_st, 0);
    lit("unlock_retry", int'(o_retry), m_r, 0);

    // OV and shoot-through in the same cycle.
    step(1, 8'd20, 4'b0110, T_BOOT + T_FORCE + 1);
    step(1, 8'd60, 4'b0101);
    lit("both_fault", int'(o_fault), int'(m_f), 3);
    step(0, 8'd20, 4'b0110);

    // Asynchronous reset between edges while in RUN.
    step(1, 8'd20, 4'b0110, T_BOOT + T_FORCE + 2);
    lit("pre_rst_Q", int'(o_Q), int'(m_q), 4'b0110);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("async_Q", int'(o_Q), 0);
    cmp("async_rstn", int'(o_rstn), 0);
    cmp("async_state", int'(o_state), 0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int i = 0; i < 20000; i++) begin
      r  = $urandom_range(0, 999);
      re = (r < 3) ? 1'b0 : 1'b1;
      r  = $urandom_range(0, 999);
      if (r < 985)      rv = 8'($urandom_range(0, 50));
      else if (r < 990) rv = 8'd50;
      else if (r < 995) rv = 8'd51;
      else              rv = 8'($urandom_range(52, 255));
      rq = 4'($urandom_range(0, 15));
      if (((rq[0] & rq[2]) | (rq[1] & rq[3])) && $urandom_range(0, 299) != 0)
        rq = rq & 4'b0011;
      step(re, rv, rq);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
